// File: rtl/stream_detect_sched_if.sv
// Requester-side and detector-side signals of the round-robin detector scheduler.
// The scheduler sits on the slave modport; the requesters, detector and bench sit on the master modport.
interface stream_detect_sched_if #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2,
    parameter int WIDTH   = 4,
    parameter int BEAT_W  = 4
);
    logic [NUM_REQ-1:0]       i_req;
    logic [NUM_REQ-1:0]       i_last;
    logic [NUM_REQ*WIDTH-1:0] i_sym;
    logic                     i_det_hit;
    logic [NUM_REQ-1:0]       o_gnt;
    logic                     o_det_clr;
    logic                     o_det_vld;
    logic [WIDTH-1:0]         o_det_sym;
    logic                     o_done;
    logic [ID_W-1:0]          o_id;
    logic                     o_hit;
    logic                     o_abort;
    logic [BEAT_W-1:0]        o_beats;

    modport master (
        output i_req, i_last, i_sym, i_det_hit,
        input  o_gnt, o_det_clr, o_det_vld, o_det_sym, o_done, o_id, o_hit, o_abort, o_beats
    );

    modport slave (
        input  i_req, i_last, i_sym, i_det_hit,
        output o_gnt, o_det_clr, o_det_vld, o_det_sym, o_done, o_id, o_hit, o_abort, o_beats
    );
endinterface

// File: rtl/stream_detect_sched.sv
// Round-robin scheduler sharing one symbol-stream detector: grant, clear, stream, drain, report.
// Optional macro DETECT_TIMEOUT_EN ends a burst after MAX_BURST beats without i_last.
module stream_detect_sched #(
    parameter int NUM_REQ   = 4,
    parameter int ID_W      = 2,
    parameter int WIDTH     = 4,
    parameter int BEAT_W    = 4,
    parameter int MAX_BURST = 8,
    parameter int DET_LAT   = 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    stream_detect_sched_if.slave  bus
);

    localparam int DRAIN_W = (DET_LAT > 1) ? $clog2(DET_LAT) : 1;
    localparam logic [NUM_REQ-1:0] ONE_REQ = NUM_REQ'(1);

    if (NUM_REQ > 2**ID_W || MAX_BURST > 2**BEAT_W - 1) begin : g_bad_cfg
        $error("stream_detect_sched: NUM_REQ or MAX_BURST out of range");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_STREAM,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t               r_state, w_stateNext;
    logic [ID_W-1:0]      r_idx, w_idxNext;
    logic [ID_W-1:0]      r_rrPtr, w_rrNext;
    logic [BEAT_W-1:0]    r_beats, w_beatsNext;
    logic                 r_hit, w_hitNext;
    logic                 r_abort, w_abortNext;
    logic [DRAIN_W-1:0]   r_drainCnt, w_drainNext;

    logic [NUM_REQ-1:0]   w_upMask, w_pool, w_gntNext;
    logic [ID_W-1:0]      w_winner;
    logic                 w_anyReq, w_reqSel, w_lastSel;
    logic [WIDTH-1:0]     w_symSel;

    // Requests at or above the pointer win first; otherwise wrap to the lowest index.
    assign w_upMask = ~((ONE_REQ << r_rrPtr) - ONE_REQ);
    assign w_pool   = (|(bus.i_req & w_upMask)) ? (bus.i_req & w_upMask) : bus.i_req;
    assign w_anyReq = |bus.i_req;

    always_comb begin
        w_winner = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (w_pool[k]) w_winner = ID_W'(k);
        end
    end

    always_comb begin
        w_symSel = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (ID_W'(k) == r_idx) w_symSel = bus.i_sym[k*WIDTH +: WIDTH];
        end
    end

    assign w_reqSel  = bus.i_req[r_idx];
    assign w_lastSel = bus.i_last[r_idx];

    assign bus.o_det_vld = (r_state == S_STREAM) && w_reqSel;
    assign bus.o_det_sym = (r_state == S_STREAM) ? w_symSel : '0;

    always_comb begin
        w_stateNext = r_state;
        w_idxNext   = r_idx;
        w_rrNext    = r_rrPtr;
        w_beatsNext = r_beats;
        w_hitNext   = r_hit;
        w_abortNext = r_abort;
        w_drainNext = r_drainCnt;
        case (r_state)
            S_IDLE: begin
                if (w_anyReq) begin
                    w_idxNext   = w_winner;
                    w_beatsNext = '0;
                    w_hitNext   = 1'b0;
                    w_abortNext = 1'b0;
                    w_stateNext = S_CLEAR;
                end
            end
            S_CLEAR: begin
                w_stateNext = S_STREAM;
            end
            S_STREAM: begin
                w_hitNext   = r_hit | bus.i_det_hit;
                w_drainNext = '0;
                if (!w_reqSel) begin
                    w_abortNext = 1'b1;
                    w_stateNext = S_DRAIN;
                end else begin
                    if (r_beats != '1) w_beatsNext = r_beats + BEAT_W'(1);
                    if (w_lastSel) begin
                        w_stateNext = S_DRAIN;
`ifdef DETECT_TIMEOUT_EN
                    end else if (r_beats == BEAT_W'(MAX_BURST - 1)) begin
                        w_abortNext = 1'b1;
                        w_stateNext = S_DRAIN;
`endif
                    end
                end
            end
            S_DRAIN: begin
                w_hitNext = r_hit | bus.i_det_hit;
                if (r_drainCnt == DRAIN_W'(DET_LAT - 1)) w_stateNext = S_DONE;
                else                                     w_drainNext = r_drainCnt + DRAIN_W'(1);
            end
            S_DONE: begin
                w_rrNext    = (int'(r_idx) == NUM_REQ - 1) ? '0 : r_idx + ID_W'(1);
                w_stateNext = S_IDLE;
            end
            default: w_stateNext = S_IDLE;
        endcase
    end

    always_comb begin
        w_gntNext = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_gntNext[k] = (w_stateNext == S_STREAM) && (ID_W'(k) == w_idxNext);
        end
    end

    // Result outputs are captured only on the DRAIN->DONE edge so they hold until the next DONE.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state       <= S_IDLE;
            r_idx         <= '0;
            r_rrPtr       <= '0;
            r_beats       <= '0;
            r_hit         <= 1'b0;
            r_abort       <= 1'b0;
            r_drainCnt    <= '0;
            bus.o_gnt     <= '0;
            bus.o_det_clr <= 1'b0;
            bus.o_done    <= 1'b0;
            bus.o_id      <= '0;
            bus.o_hit     <= 1'b0;
            bus.o_abort   <= 1'b0;
            bus.o_beats   <= '0;
        end else begin
            r_state       <= w_stateNext;
            r_idx         <= w_idxNext;
            r_rrPtr       <= w_rrNext;
            r_beats       <= w_beatsNext;
            r_hit         <= w_hitNext;
            r_abort       <= w_abortNext;
            r_drainCnt    <= w_drainNext;
            bus.o_gnt     <= w_gntNext;
            bus.o_det_clr <= (w_stateNext == S_CLEAR);
            bus.o_done    <= (w_stateNext == S_DONE);
            if (r_state == S_DRAIN && w_stateNext == S_DONE) begin
                bus.o_id    <= r_idx;
                bus.o_hit   <= w_hitNext;
                bus.o_abort <= r_abort;
                bus.o_beats <= r_beats;
            end
        end
    end

endmodule
